// File: rtl/hazard_ctrl.sv
// Hazard control for a 3-stage-tracked in-order pipeline.
// Inserts one bubble on a load-use hazard and selects operand bypasses from EX/MEM or MEM/WB.
module hazard_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             if_valid,
    input  logic [7:0]       if_instr,
    output logic             if_ready,
    output logic             id_bubble,
    output logic [1:0]       fwd_rs,
    output logic [1:0]       fwd_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        OpNoop = 2'b00,
        OpAdd  = 2'b01,
        OpSw   = 2'b10,
        OpLw   = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        FwdRegfile = 2'b00,
        FwdExMem   = 2'b01,
        FwdMemWb   = 2'b10
    } fwd_e;

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    // Decoded view of the IF/ID instruction
    opcode_e    dec_op;
    logic [2:0] dec_rs;
    logic [2:0] dec_rd;
    logic       dec_reads_rs;
    logic       dec_reads_rd;
    logic       dec_writes;
    logic       dec_is_load;

    // In-flight slots. The WB slot carries no state: the register file is
    // write-before-read, so nothing downstream of MEM is ever consulted.
    logic       ex_vw_q,  ex_vw_d;
    logic [2:0] ex_rd_q,  ex_rd_d;
    logic       ex_ld_q,  ex_ld_d;
    logic       mem_vw_q, mem_vw_d;
    logic [2:0] mem_rd_q, mem_rd_d;

    fwd_e             fwd_rs_q, fwd_rs_d;
    fwd_e             fwd_rd_q, fwd_rd_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;

    logic stall;
    logic accept;
    logic hit_rs;
    logic hit_rd;

    always_comb begin
        dec_op       = opcode_e'(if_instr[7:6]);
        dec_rs       = if_instr[5:3];
        dec_rd       = if_instr[2:0];
        dec_reads_rs = 1'b0;
        dec_reads_rd = 1'b0;
        dec_writes   = 1'b0;
        dec_is_load  = 1'b0;
        unique case (dec_op)
            OpAdd: begin
                dec_reads_rs = 1'b1;
                dec_reads_rd = 1'b1;
                dec_writes   = 1'b1;
            end
            OpLw: begin
                dec_reads_rs = 1'b1;
                dec_writes   = 1'b1;
                dec_is_load  = 1'b1;
            end
            OpSw: begin
                dec_reads_rs = 1'b1;
                dec_reads_rd = 1'b1;
            end
            OpNoop: ;
            default: ;
        endcase
    end

    // ex_vw_q already excludes r0, so a load to r0 never stalls
    always_comb begin
        hit_rs = dec_reads_rs && (dec_rs == ex_rd_q);
        hit_rd = dec_reads_rd && (dec_rd == ex_rd_q);
        stall  = if_valid && ex_vw_q && ex_ld_q && (hit_rs || hit_rd);
        accept = if_valid && !stall;
    end

    assign if_ready  = !stall;
    assign id_bubble = stall || !if_valid;

    function automatic fwd_e fwd_sel(
        input logic       used,
        input logic [2:0] r,
        input logic       ex_vw,
        input logic [2:0] ex_rd,
        input logic       mem_vw,
        input logic [2:0] mem_rd
    );
        fwd_e sel;
        sel = FwdRegfile;
        if (used && (r != 3'd0)) begin
            if (ex_vw && (ex_rd == r)) begin
                sel = FwdExMem;
            end else if (mem_vw && (mem_rd == r)) begin
                sel = FwdMemWb;
            end
        end
        return sel;
    endfunction

    always_comb begin
        mem_vw_d = ex_vw_q;
        mem_rd_d = ex_rd_q;
        ex_vw_d  = 1'b0;
        ex_rd_d  = 3'd0;
        ex_ld_d  = 1'b0;
        fwd_rs_d = FwdRegfile;
        fwd_rd_d = FwdRegfile;
        cnt_d    = cnt_q;

        if (accept) begin
            ex_vw_d  = dec_writes && (dec_rd != 3'd0);
            ex_rd_d  = dec_rd;
            ex_ld_d  = dec_is_load;
            fwd_rs_d = fwd_sel(dec_reads_rs, dec_rs, ex_vw_q, ex_rd_q, mem_vw_q, mem_rd_q);
            fwd_rd_d = fwd_sel(dec_reads_rd, dec_rd, ex_vw_q, ex_rd_q, mem_vw_q, mem_rd_q);
        end

        if (stall && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_vw_q  <= 1'b0;
            ex_rd_q  <= 3'd0;
            ex_ld_q  <= 1'b0;
            mem_vw_q <= 1'b0;
            mem_rd_q <= 3'd0;
            fwd_rs_q <= FwdRegfile;
            fwd_rd_q <= FwdRegfile;
            cnt_q    <= '0;
        end else begin
            ex_vw_q  <= ex_vw_d;
            ex_rd_q  <= ex_rd_d;
            ex_ld_q  <= ex_ld_d;
            mem_vw_q <= mem_vw_d;
            mem_rd_q <= mem_rd_d;
            fwd_rs_q <= fwd_rs_d;
            fwd_rd_q <= fwd_rd_d;
            cnt_q    <= cnt_d;
        end
    end

    assign fwd_rs    = fwd_rs_q;
    assign fwd_rd    = fwd_rd_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard pairs, async/mid-stall reset,
// randomized instruction streams and counter saturation against a history-based model.
module tb_hazard_ctrl;

    localparam int CNT_W = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             if_valid;
    logic [7:0]       if_instr;
    logic             if_ready;
    logic             id_bubble;
    logic [1:0]       fwd_rs;
    logic [1:0]       fwd_rd;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_valid  (if_valid),
        .if_instr  (if_instr),
        .if_ready  (if_ready),
        .id_bubble (id_bubble),
        .fwd_rs    (fwd_rs),
        .fwd_rd    (fwd_rd),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ready;
        int bubble;
        int frs;
        int frd;
        int cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: the instructions that entered EX one (h0) and two (h1) cycles ago; -1 = bubble
    int h0 = -1;
    int h1 = -1;
    int m_frs = 0;
    int m_frd = 0;
    int m_cnt = 0;

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic int op_of(input int i);
        return (i >> 6) & 3;
    endfunction

    function automatic int rs_of(input int i);
        return (i >> 3) & 7;
    endfunction

    function automatic int rd_of(input int i);
        return i & 7;
    endfunction

    function automatic bit uses_rs(input int i);
        return (i >= 0) && (op_of(i) != 0);
    endfunction

    function automatic bit uses_rd(input int i);
        return (i >= 0) && (op_of(i) == 1 || op_of(i) == 2);
    endfunction

    // Destination register written, or -1 when nothing (or r0) is written
    function automatic int dest_of(input int i);
        if (i < 0) return -1;
        if ((op_of(i) == 1 || op_of(i) == 3) && rd_of(i) != 0) return rd_of(i);
        return -1;
    endfunction

    function automatic int bypass(input bit used, input int r);
        if (!used || r == 0) return 0;
        if (dest_of(h0) == r) return 1;
        if (dest_of(h1) == r) return 2;
        return 0;
    endfunction

    function automatic bit model_stall(input bit v, input int i);
        int ld;
        if (!v || h0 < 0 || op_of(h0) != 3) return 0;
        ld = dest_of(h0);
        if (ld < 0) return 0;
        return (uses_rs(i) && rs_of(i) == ld) || (uses_rd(i) && rd_of(i) == ld);
    endfunction

    task automatic model_reset();
        h0 = -1;
        h1 = -1;
        m_frs = 0;
        m_frd = 0;
        m_cnt = 0;
    endtask

    // One cycle: drive inputs, queue what the DUT must show this cycle, advance the model
    task automatic step(input bit v, input logic [7:0] instr);
        exp_t e;
        bit   st;
        int   ent;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        if_valid = v;
        if_instr = instr;
        st = model_stall(v, int'(instr));
        e.ready  = st ? 0 : 1;
        e.bubble = (st || !v) ? 1 : 0;
        e.frs    = m_frs;
        e.frd    = m_frd;
        e.cnt    = m_cnt;
        exp_q.push_back(e);
        if (v && !st) begin
            ent   = int'(instr);
            m_frs = bypass(uses_rs(ent), rs_of(ent));
            m_frd = bypass(uses_rd(ent), rd_of(ent));
        end else begin
            ent   = -1;
            m_frs = 0;
            m_frd = 0;
        end
        if (st && m_cnt < CNT_MAX) m_cnt++;
        h1 = h0;
        h0 = ent;
    endtask

    // Reset pulsed asynchronously in the middle of the current cycle
    task automatic reset_mid();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", int'(if_ready), 1);
        chk("rst_mid_bubble", int'(id_bubble), if_valid ? 0 : 1);
        chk("rst_mid_fwd_rs", int'(fwd_rs), 0);
        chk("rst_mid_fwd_rd", int'(fwd_rd), 0);
        chk("rst_mid_cnt", int'(stall_cnt), 0);
        model_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("if_ready", int'(if_ready), e.ready);
                chk("id_bubble", int'(id_bubble), e.bubble);
                chk("fwd_rs", int'(fwd_rs), e.frs);
                chk("fwd_rd", int'(fwd_rd), e.frd);
                chk("stall_cnt", int'(stall_cnt), e.cnt);
            end
        end
    end

    initial begin : stimulus
        logic [7:0] ri;
        rst_n    = 1'b0;
        if_valid = 1'b1;
        if_instr = 8'hCB;
        #2;
        chk("rst_ready", int'(if_ready), 1);
        chk("rst_bubble", int'(id_bubble), 0);
        chk("rst_fwd_rs", int'(fwd_rs), 0);
        chk("rst_fwd_rd", int'(fwd_rd), 0);
        chk("rst_cnt", int'(stall_cnt), 0);
        if_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Load-use: lw r3,[r1] then add r4+=r3
        step(1'b1, 8'hCB);
        step(1'b1, 8'h5C);
        step(1'b1, 8'h5C);
        step(1'b0, 8'h00);
        // ALU forward: add r2+=r1 then add r5+=r2
        step(1'b1, 8'h4A);
        step(1'b1, 8'h55);
        step(1'b0, 8'h00);
        // Zero register: lw r0 then read r0
        step(1'b1, 8'hC8);
        step(1'b1, 8'h42);
        step(1'b0, 8'h00);
        // Store data hazard
        step(1'b1, 8'hCB);
        step(1'b1, 8'h8B);
        step(1'b1, 8'h8B);
        step(1'b0, 8'h00);
        // Same pair with reset landing in the stall cycle
        step(1'b1, 8'hCB);
        step(1'b1, 8'h8B);
        reset_mid();
        step(1'b1, 8'h8B);
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);

        // Random streams on a small register set so hazards are frequent
        for (int k = 0; k < 500; k++) begin
            ri = {2'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), 3'($urandom_range(0, 3))};
            step(($urandom_range(0, 9) < 8), ri);
        end

        // Saturation: 300 load-use pairs
        for (int k = 0; k < 300; k++) begin
            step(1'b1, 8'hCB);
            step(1'b1, 8'h5C);
            step(1'b1, 8'h5C);
        end
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        #1;
        chk("sat_hold", int'(stall_cnt), CNT_MAX);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
